// File: rtl/spi_miso_tx.sv
// Slave-side SPI MISO serialiser with a one-entry holding register for gapless frames.
// Optional sticky underrun flag enabled by defining SPI_MISO_TX_UNDERRUN_EN.
module spi_miso_tx #(
  parameter int   DATA_W   = 8,
  parameter logic IDLE_BIT = 1'b1
) (
  input  logic              spi_clk,
  input  logic              spi_rst_n,
  input  logic              spi_cs,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              spi_miso_out,
  output logic              spi_miso_oe,
  output logic              tx_done,
  output logic              tx_underrun
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  // tx_valid/tx_ready: a write is taken on a rising edge where both are high;
  // tx_ready is simply "holding register empty" and never depends on tx_valid.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_hold;
  logic              r_hold_full;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              r_miso;
  logic              w_miso_nxt;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_frame_start;
  logic              w_take;
  logic              w_write;

  assign w_write = tx_valid && !r_hold_full;

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_cnt_nxt     = r_cnt;
    w_miso_nxt    = IDLE_BIT;
    w_done_nxt    = 1'b0;
    w_frame_start = 1'b0;
    w_take        = 1'b0;
    if (spi_cs) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      w_state_nxt = SHIFT;
      w_cnt_nxt   = (r_cnt == LAST_CNT) ? '0 : r_cnt + CNT_W'(1);
      w_done_nxt  = (r_cnt == LAST_CNT);
      if (r_cnt == '0) begin
        w_frame_start = 1'b1;
        // An empty holding register at frame start sends a whole frame of IDLE_BIT.
        if (r_hold_full) begin
          w_take      = 1'b1;
          w_miso_nxt  = r_hold[DATA_W-1];
          w_shift_nxt = {r_hold[DATA_W-2:0], IDLE_BIT};
        end else begin
          w_miso_nxt  = IDLE_BIT;
          w_shift_nxt = {DATA_W{IDLE_BIT}};
        end
      end else begin
        w_miso_nxt  = r_shift[DATA_W-1];
        w_shift_nxt = {r_shift[DATA_W-2:0], IDLE_BIT};
      end
    end
  end

  always_ff @(posedge spi_clk or negedge spi_rst_n) begin
    if (!spi_rst_n) begin
      r_state <= IDLE;
      r_shift <= {DATA_W{IDLE_BIT}};
      r_cnt   <= '0;
      r_miso  <= IDLE_BIT;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_miso  <= w_miso_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Take and write are exclusive: take needs a full register, write an empty one.
  always_ff @(posedge spi_clk or negedge spi_rst_n) begin
    if (!spi_rst_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_take) begin
      r_hold_full <= 1'b0;
    end else if (w_write) begin
      r_hold      <= tx_data;
      r_hold_full <= 1'b1;
    end
  end

`ifdef SPI_MISO_TX_UNDERRUN_EN
  logic r_underrun;

  always_ff @(posedge spi_clk or negedge spi_rst_n) begin
    if (!spi_rst_n) begin
      r_underrun <= 1'b0;
    end else if (w_frame_start && !r_hold_full) begin
      r_underrun <= 1'b1;
    end
  end

  assign tx_underrun = r_underrun;
`else
  assign tx_underrun = 1'b0;
`endif

  assign tx_ready     = !r_hold_full;
  assign spi_miso_out = r_miso;
  assign spi_miso_oe  = (r_state == SHIFT);
  assign tx_done      = r_done;

endmodule

// File: tb/tb_spi_miso_tx.sv
// Directed self-checking bench for spi_miso_tx (8-bit frames, IDLE_BIT = 1).
// Underrun expectations follow SPI_MISO_TX_UNDERRUN_EN as compiled.
module tb_spi_miso_tx;

`ifdef SPI_MISO_TX_UNDERRUN_EN
  localparam logic UR_EN = 1'b1;
`else
  localparam logic UR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       cs;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       miso;
  logic       oe;
  logic       done;
  logic       underrun;

  int checks   = 0;
  int failures = 0;

  spi_miso_tx dut (
    .spi_clk      (clk),
    .spi_rst_n    (rst_n),
    .spi_cs       (cs),
    .tx_data      (data),
    .tx_valid     (valid),
    .tx_ready     (ready),
    .spi_miso_out (miso),
    .spi_miso_oe  (oe),
    .tx_done      (done),
    .tx_underrun  (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    data  = b;
    valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cs = 1'b1; valid = 1'b0; data = 8'h00;
    tick(); tick();
    checks++; if (miso !== 1'b1) begin failures++; $display("FAIL reset_miso got=%b exp=1", miso); end
    checks++; if (oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", oe); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_frame();
    logic [7:0] pat = 8'hA5;
    int n_done = 0;
    write_byte(pat);
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL single_ready_after_write got=%b exp=0", ready); end
    cs = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (done === 1'b1) n_done++;
      checks++; if (miso !== pat[8-e]) begin failures++; $display("FAIL single_bit edge=%0d got=%b exp=%b", e, miso, pat[8-e]); end
      checks++; if (oe !== 1'b1) begin failures++; $display("FAIL single_oe edge=%0d got=%b exp=1", e, oe); end
      checks++; if (done !== (e == 8)) begin failures++; $display("FAIL single_done edge=%0d got=%b exp=%b", e, done, (e == 8)); end
      if (e == 1) begin
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL single_ready_after_start got=%b exp=1", ready); end
      end
    end
    cs = 1'b1;
    tick();
    if (done === 1'b1) n_done++;
    checks++; if (n_done != 1) begin failures++; $display("FAIL single_done_count got=%0d exp=1", n_done); end
    checks++; if (oe !== 1'b0) begin failures++; $display("FAIL single_oe_idle got=%b exp=0", oe); end
    checks++; if (miso !== 1'b1) begin failures++; $display("FAIL single_miso_idle got=%b exp=1", miso); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pat = 16'hE155;
    write_byte(8'hE1);
    cs = 1'b0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      checks++; if (miso !== pat[16-e]) begin failures++; $display("FAIL b2b_bit edge=%0d got=%b exp=%b", e, miso, pat[16-e]); end
      checks++; if (done !== (e == 8 || e == 16)) begin failures++; $display("FAIL b2b_done edge=%0d got=%b exp=%b", e, done, (e == 8 || e == 16)); end
      if (e == 1) begin
        data = 8'h55; valid = 1'b1;
      end else if (e == 2) begin
        valid = 1'b0;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_after_write got=%b exp=0", ready); end
      end else if (e == 9) begin
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_second_start got=%b exp=1", ready); end
      end
    end
    cs = 1'b1;
    tick();
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL b2b_no_underrun got=%b exp=0", underrun); end
  endtask

  task automatic test_underrun();
    cs = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++; if (miso !== 1'b1) begin failures++; $display("FAIL underrun_bit edge=%0d got=%b exp=1", e, miso); end
      checks++; if (done !== (e == 8)) begin failures++; $display("FAIL underrun_done edge=%0d got=%b exp=%b", e, done, (e == 8)); end
    end
    checks++; if (underrun !== UR_EN) begin failures++; $display("FAIL underrun_flag got=%b exp=%b", underrun, UR_EN); end
    cs = 1'b1;
    tick();
    checks++; if (underrun !== UR_EN) begin failures++; $display("FAIL underrun_sticky got=%b exp=%b", underrun, UR_EN); end
  endtask

  task automatic test_abort();
    logic [7:0] first = 8'h3C;
    logic [7:0] pat   = 8'h81;
    write_byte(first);
    cs = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      tick();
      checks++; if (miso !== first[8-e]) begin failures++; $display("FAIL abort_bit edge=%0d got=%b exp=%b", e, miso, first[8-e]); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done edge=%0d got=%b exp=0", e, done); end
    end
    cs = 1'b1;
    tick();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b exp=0", done); end
    checks++; if (oe !== 1'b0) begin failures++; $display("FAIL abort_oe got=%b exp=0", oe); end
    write_byte(pat);
    cs = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++; if (miso !== pat[8-e]) begin failures++; $display("FAIL abort_next_bit edge=%0d got=%b exp=%b", e, miso, pat[8-e]); end
      checks++; if (done !== (e == 8)) begin failures++; $display("FAIL abort_next_done edge=%0d got=%b exp=%b", e, done, (e == 8)); end
    end
    cs = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_frame();
    write_byte(8'hFF);
    cs = 1'b0;
    tick(); tick(); tick();
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready_pre got=%b exp=1", ready); end
    write_byte(8'h00);
    checks++; if (ready !== 1'b0) begin failures++; $display("FAIL rstmid_hold_full got=%b exp=0", ready); end
    rst_n = 1'b0;
    #1;
    checks++; if (miso !== 1'b1) begin failures++; $display("FAIL rstmid_miso got=%b exp=1", miso); end
    checks++; if (oe !== 1'b0) begin failures++; $display("FAIL rstmid_oe got=%b exp=0", oe); end
    checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", ready); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL rstmid_underrun got=%b exp=0", underrun); end
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++; if (miso !== 1'b1) begin failures++; $display("FAIL rstmid_after_bit edge=%0d got=%b exp=1", e, miso); end
      checks++; if (done !== (e == 8)) begin failures++; $display("FAIL rstmid_after_done edge=%0d got=%b exp=%b", e, done, (e == 8)); end
    end
    checks++; if (underrun !== UR_EN) begin failures++; $display("FAIL rstmid_after_underrun got=%b exp=%b", underrun, UR_EN); end
    cs = 1'b1;
    tick();
  endtask

  task automatic test_write_on_start();
    logic [15:0] pat = 16'hFF96;
    cs = 1'b0; data = 8'h96; valid = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 1) begin
        valid = 1'b0;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL wos_ready_kept got=%b exp=0", ready); end
      end
      if (e == 9) begin
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL wos_ready_second got=%b exp=1", ready); end
      end
      checks++; if (miso !== pat[16-e]) begin failures++; $display("FAIL wos_bit edge=%0d got=%b exp=%b", e, miso, pat[16-e]); end
      checks++; if (done !== (e == 8 || e == 16)) begin failures++; $display("FAIL wos_done edge=%0d got=%b exp=%b", e, done, (e == 8 || e == 16)); end
    end
    checks++; if (underrun !== UR_EN) begin failures++; $display("FAIL wos_underrun got=%b exp=%b", underrun, UR_EN); end
    cs = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_mid_frame();
    test_write_on_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
